// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared defaults and derived sizes for the register file and
//               its destination decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    // Index of the hard-wired zero register
    localparam int ZERO_REG_INDEX = 0;

    // Number of registers addressed by an index of the given width
    function automatic int num_regs(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/register_file_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder
// Description : Generalised destination decoder. Drives a single bit at the
//               position given by 'in' when 'en' is high, all zero otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder #(
    parameter int IN_WIDTH = 4
) (
    input  logic [IN_WIDTH-1:0]      in,
    input  logic                     en,
    output logic [2**IN_WIDTH-1:0]   out
);

    localparam int c_NUM_OUT = 2**IN_WIDTH;

    // One compare per output bit, gated by the enable
    always_comb begin
        out = '0;
        for (int i = 0; i < c_NUM_OUT; i++) begin
            out[i] = en && (in == i[IN_WIDTH-1:0]);
        end
    end

endmodule : onehot_decoder
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : N x DATA_WIDTH register file with one synchronous write port,
//               two combinational read ports with same-cycle write forwarding
//               and a per-register busy scoreboard for in-flight writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [2**ADDR_WIDTH-1:0] wr_select,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_a,
    output logic [DATA_WIDTH-1:0]   rd_data_a,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_b,
    output logic [DATA_WIDTH-1:0]   rd_data_b,
    input  logic                    rsv_en,
    input  logic [ADDR_WIDTH-1:0]   rsv_addr,
    output logic                    busy_a,
    output logic                    busy_b
);

    localparam int c_NUM_REGS = num_regs(ADDR_WIDTH);
    localparam int c_NUM_PORTS = 2;

    logic [c_NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [c_NUM_REGS-1:0]                 busy_q, busy_d;

    logic [c_NUM_REGS-1:0] w_wr_vec;
    logic [c_NUM_REGS-1:0] w_rsv_dec;
    logic [c_NUM_REGS-1:0] w_rsv_vec;

    // wr_select is the raw decode; register 0 is still reported here
    onehot_decoder #(
        .IN_WIDTH (ADDR_WIDTH)
    ) u_wr_decoder (
        .in  (wr_addr),
        .en  (wr_en),
        .out (wr_select)
    );

    onehot_decoder #(
        .IN_WIDTH (ADDR_WIDTH)
    ) u_rsv_decoder (
        .in  (rsv_addr),
        .en  (rsv_en),
        .out (w_rsv_dec)
    );

    // Suppress write and reserve of the hard-wired zero register at the array
    always_comb begin
        w_wr_vec  = wr_select;
        w_rsv_vec = w_rsv_dec;
        if (ZERO_REG != 0) begin
            w_wr_vec[ZERO_REG_INDEX]  = 1'b0;
            w_rsv_vec[ZERO_REG_INDEX] = 1'b0;
        end
    end

    // Next state: a write stores data and clears busy; a reservation applied
    // afterwards wins, so write+reserve on one register leaves it busy
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            if (w_wr_vec[i]) begin
                regs_d[i] = wr_data;
                busy_d[i] = 1'b0;
            end
            if (w_rsv_vec[i]) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // State registers; reset clears data and discards all reservations
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [c_NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_rd_addr;
    logic [c_NUM_PORTS-1:0][DATA_WIDTH-1:0] w_rd_data;
    logic [c_NUM_PORTS-1:0]                 w_rd_busy;

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    // Identical read path per port: zero register beats forwarding beats array
    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_read_port
        logic w_zero;
        logic w_fwd;

        assign w_zero = (ZERO_REG != 0) &&
                        (w_rd_addr[p] == ADDR_WIDTH'(ZERO_REG_INDEX));
        assign w_fwd  = wr_en && (wr_addr == w_rd_addr[p]);

        assign w_rd_data[p] = w_zero ? '0 :
                              w_fwd  ? wr_data :
                                       regs_q[w_rd_addr[p]];
        assign w_rd_busy[p] = !w_zero && !w_fwd && busy_q[w_rd_addr[p]];
    end

    assign rd_data_a = w_rd_data[0];
    assign rd_data_b = w_rd_data[1];
    assign busy_a    = w_rd_busy[0];
    assign busy_b    = w_rd_busy[1];

endmodule : register_file
`default_nettype wire
